// File: rtl/seven_seg_scan_if.sv
// Bundle between the stopwatch counter/board pins and the seven-segment scan controller.
// The master side supplies enable and BCD digits; the slave (controller) drives segments, anodes and the frame pulse.
interface seven_seg_scan_if;
    logic       enable;
    logic [3:0] Minutes;
    logic [3:0] Tens_Seconds;
    logic [3:0] Ones_Seconds;
    logic [3:0] Tenths_Seconds;
    logic [0:6] Seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    modport master (
        output enable, Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds,
        input  Seg, dp, an, frame_done
    );

    modport slave (
        input  enable, Minutes, Tens_Seconds, Ones_Seconds, Tenths_Seconds,
        output Seg, dp, an, frame_done
    );
endinterface

// File: rtl/seven_seg_scan_controller.sv
// Scans four BCD stopwatch digits onto an active-low seven-segment bus with per-slot blanking
// and a once-per-frame digit snapshot. Optional feature: LEADING_ZERO_BLANK_EN (suppress leading zeros).
module seven_seg_scan_controller #(
    parameter int REFRESH_DIV  = 50000,
    parameter int BLANK_CYCLES = 500
) (
    input  logic            clk,
    input  logic            reset,
    seven_seg_scan_if.slave bus
);

    localparam int CW = $clog2(REFRESH_DIV);
    localparam logic [CW-1:0] CNT_LAST   = CW'(REFRESH_DIV - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

    if (REFRESH_DIV < 2 || BLANK_CYCLES < 1 || BLANK_CYCLES >= REFRESH_DIV) begin : g_param_check
        $error("seven_seg_scan_controller: need REFRESH_DIV >= 2 and 1 <= BLANK_CYCLES < REFRESH_DIV");
    end

    typedef enum logic [1:0] {
        IDLE,
        BLANK,
        DRIVE
    } state_t;

    state_t          state, state_next;
    logic [CW-1:0]   cnt, cnt_next;
    logic [1:0]      idx, idx_next;
    logic [3:0][3:0] snap, snap_next;
    logic [3:0][3:0] digits_in;

    logic [0:6] seg_next;
    logic       dp_next;
    logic [3:0] an_next;
    logic       fd_next;
    logic       slot_dark;
    logic       driving;

    // Active-low a..g patterns; non-BCD codes light nothing but keep the anode driven.
    function automatic logic [0:6] decode(input logic [3:0] d);
        logic [0:6] s;
        case (d)
            4'd0:    s = 7'b0000001;
            4'd1:    s = 7'b1001111;
            4'd2:    s = 7'b0010010;
            4'd3:    s = 7'b0000110;
            4'd4:    s = 7'b1001100;
            4'd5:    s = 7'b0100100;
            4'd6:    s = 7'b0100000;
            4'd7:    s = 7'b0001111;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0000100;
            default: s = 7'b1111111;
        endcase
        return s;
    endfunction

    assign digits_in = {bus.Minutes, bus.Tens_Seconds, bus.Ones_Seconds, bus.Tenths_Seconds};

    // Outputs are computed from the next-state values so the registered pins line up with the state they describe.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        idx_next   = idx;
        snap_next  = snap;

        case (state)
            IDLE: begin
                if (bus.enable) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = '0;
                    snap_next  = digits_in;
                end
            end
            default: begin
                if (!bus.enable) begin
                    state_next = IDLE;
                    cnt_next   = '0;
                    idx_next   = '0;
                end else if (cnt == CNT_LAST) begin
                    state_next = BLANK;
                    cnt_next   = '0;
                    idx_next   = idx + 2'd1;
                    if (idx == 2'd3) begin
                        snap_next = digits_in;
                    end
                end else begin
                    cnt_next   = cnt + 1'b1;
                    state_next = (cnt >= BLANK_LAST) ? DRIVE : BLANK;
                end
            end
        endcase

`ifdef LEADING_ZERO_BLANK_EN
        slot_dark = ((idx_next == 2'd3) && (snap_next[3] == 4'd0)) ||
                    ((idx_next == 2'd2) && (snap_next[3] == 4'd0) && (snap_next[2] == 4'd0));
`else
        slot_dark = 1'b0;
`endif

        driving  = (state_next == DRIVE) && !slot_dark;
        an_next  = 4'b1111;
        seg_next = 7'b1111111;
        dp_next  = 1'b1;
        if (driving) begin
            an_next[idx_next] = 1'b0;
            seg_next          = decode(snap_next[idx_next]);
            dp_next           = !idx_next[0];
        end
        fd_next = (state_next != IDLE) && (cnt_next == CNT_LAST) && (idx_next == 2'd3);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            cnt            <= '0;
            idx            <= '0;
            snap           <= '0;
            bus.Seg        <= 7'b1111111;
            bus.dp         <= 1'b1;
            bus.an         <= 4'b1111;
            bus.frame_done <= 1'b0;
        end else begin
            state          <= state_next;
            cnt            <= cnt_next;
            idx            <= idx_next;
            snap           <= snap_next;
            bus.Seg        <= seg_next;
            bus.dp         <= dp_next;
            bus.an         <= an_next;
            bus.frame_done <= fd_next;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan_controller.sv
// Self-checking bench for seven_seg_scan_controller (REFRESH_DIV=8, BLANK_CYCLES=2): a frame-time
// model checked every cycle, plus directed literal expectations.
module tb_seven_seg_scan_controller;

    localparam int DIV   = 8;
    localparam int BLANK = 2;
    localparam int FRAME = 4 * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;
    seven_seg_scan_if bus ();

    seven_seg_scan_controller #(.REFRESH_DIV(DIV), .BLANK_CYCLES(BLANK)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passes = 0;
    int curT   = 0;

    // Model state: running flag, clocks since scan start, and the digits latched for the current frame.
    bit       mRun = 1'b0;
    int       mT   = 0;
    int       mSnap [4] = '{0, 0, 0, 0};
    logic [6:0] segTable [16];

    initial begin
        segTable[0] = 7'b0000001; segTable[1] = 7'b1001111; segTable[2] = 7'b0010010;
        segTable[3] = 7'b0000110; segTable[4] = 7'b1001100; segTable[5] = 7'b0100100;
        segTable[6] = 7'b0100000; segTable[7] = 7'b0001111; segTable[8] = 7'b0000000;
        segTable[9] = 7'b0000100;
        for (int i = 10; i < 16; i++) segTable[i] = 7'b1111111;
    end

    task automatic checkOutput(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    task automatic applyStimulus(input logic en, input logic [3:0] m, input logic [3:0] ts,
                                 input logic [3:0] os, input logic [3:0] tn);
        bus.enable         = en;
        bus.Minutes        = m;
        bus.Tens_Seconds   = ts;
        bus.Ones_Seconds   = os;
        bus.Tenths_Seconds = tn;
    endtask

    task automatic advanceTo(input int target);
        repeat (target - curT) @(negedge clk);
        curT = target;
    endtask

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            mRun <= 1'b0;
            mT   <= 0;
            for (int i = 0; i < 4; i++) mSnap[i] <= 0;
        end else if (!mRun) begin
            if (bus.enable) begin
                mRun     <= 1'b1;
                mT       <= 0;
                mSnap[0] <= int'(bus.Tenths_Seconds);
                mSnap[1] <= int'(bus.Ones_Seconds);
                mSnap[2] <= int'(bus.Tens_Seconds);
                mSnap[3] <= int'(bus.Minutes);
            end
        end else if (!bus.enable) begin
            mRun <= 1'b0;
            mT   <= 0;
        end else begin
            mT <= mT + 1;
            if ((mT + 1) % FRAME == 0) begin
                mSnap[0] <= int'(bus.Tenths_Seconds);
                mSnap[1] <= int'(bus.Ones_Seconds);
                mSnap[2] <= int'(bus.Tens_Seconds);
                mSnap[3] <= int'(bus.Minutes);
            end
        end
    end

    // Every cycle: derive the pins from slot number and position within the slot.
    always @(negedge clk) begin
        int slot, pos;
        bit dark, drive;
        logic [3:0] expAn;
        logic [6:0] expSeg;
        logic expDp, expFd;
        slot = (mT / DIV) % 4;
        pos  = mT % DIV;
`ifdef LEADING_ZERO_BLANK_EN
        dark = (slot == 3 && mSnap[3] == 0) || (slot == 2 && mSnap[3] == 0 && mSnap[2] == 0);
`else
        dark = 1'b0;
`endif
        drive  = mRun && (pos >= BLANK) && !dark;
        expAn  = drive ? (4'hF & ~(4'b0001 << slot)) : 4'hF;
        expSeg = drive ? segTable[mSnap[slot]] : 7'b1111111;
        expDp  = (drive && (slot == 1 || slot == 3)) ? 1'b0 : 1'b1;
        expFd  = mRun && (mT % FRAME == FRAME - 1);
        checkOutput("model_an", {4'b0, bus.an}, {4'b0, expAn});
        checkOutput("model_seg", {1'b0, bus.Seg}, {1'b0, expSeg});
        checkOutput("model_dp", {7'b0, bus.dp}, {7'b0, expDp});
        checkOutput("model_fd", {7'b0, bus.frame_done}, {7'b0, expFd});
    end

    initial begin
        int fdCount;
        applyStimulus(1'b0, 4'd1, 4'd2, 4'd3, 4'd4);
        repeat (2) @(negedge clk);
        checkOutput("reset_an", {4'b0, bus.an}, 8'h0F);
        checkOutput("reset_seg", {1'b0, bus.Seg}, 8'h7F);
        checkOutput("reset_dp", {7'b0, bus.dp}, 8'h01);
        reset = 1'b0;
        @(negedge clk);

        // Scan inputs 1,2,3,4 and pin one cycle of each slot.
        applyStimulus(1'b1, 4'd1, 4'd2, 4'd3, 4'd4);
        curT = -1;
        advanceTo(0);
        checkOutput("slot0_blank_an", {4'b0, bus.an}, 8'h0F);
        advanceTo(2);
        checkOutput("slot0_an", {4'b0, bus.an}, 8'h0E);
        checkOutput("slot0_seg", {1'b0, bus.Seg}, {1'b0, 7'b1001100});
        checkOutput("slot0_dp", {7'b0, bus.dp}, 8'h01);
        advanceTo(10);
        checkOutput("slot1_an", {4'b0, bus.an}, 8'h0D);
        checkOutput("slot1_seg", {1'b0, bus.Seg}, {1'b0, 7'b0000110});
        checkOutput("slot1_dp", {7'b0, bus.dp}, 8'h00);
        applyStimulus(1'b1, 4'd7, 4'd2, 4'd3, 4'd9);
        advanceTo(18);
        checkOutput("slot2_an", {4'b0, bus.an}, 8'h0B);
        checkOutput("slot2_seg", {1'b0, bus.Seg}, {1'b0, 7'b0010010});
        advanceTo(26);
        checkOutput("slot3_an", {4'b0, bus.an}, 8'h07);
        checkOutput("slot3_seg_old_min", {1'b0, bus.Seg}, {1'b0, 7'b1001111});
        checkOutput("slot3_dp", {7'b0, bus.dp}, 8'h00);
        advanceTo(30);
        checkOutput("fd_early", {7'b0, bus.frame_done}, 8'h00);
        advanceTo(31);
        checkOutput("fd_pulse", {7'b0, bus.frame_done}, 8'h01);
        advanceTo(34);
        checkOutput("tenths_new_frame", {1'b0, bus.Seg}, {1'b0, 7'b0000100});
        advanceTo(58);
        checkOutput("minutes_new_frame", {1'b0, bus.Seg}, {1'b0, 7'b0001111});

        // Non-BCD tens digit blanks the segments but keeps its anode.
        applyStimulus(1'b1, 4'd7, 4'hC, 4'd3, 4'd9);
        advanceTo(82);
        checkOutput("nonbcd_an", {4'b0, bus.an}, 8'h0B);
        checkOutput("nonbcd_seg", {1'b0, bus.Seg}, 8'h7F);

        // Drop enable in slot 2, clock 5 of a frame.
        advanceTo(3 * FRAME + 2 * DIV + 5);
        applyStimulus(1'b0, 4'd7, 4'hC, 4'd3, 4'd9);
        advanceTo(3 * FRAME + 2 * DIV + 6);
        checkOutput("disable_an", {4'b0, bus.an}, 8'h0F);
        checkOutput("disable_fd", {7'b0, bus.frame_done}, 8'h00);
        repeat (40) @(negedge clk);
        applyStimulus(1'b1, 4'd5, 4'd0, 4'd8, 4'd6);
        curT = -1;
        advanceTo(0);
        checkOutput("reenable_blank", {4'b0, bus.an}, 8'h0F);
        advanceTo(2);
        checkOutput("reenable_an", {4'b0, bus.an}, 8'h0E);
        checkOutput("reenable_seg", {1'b0, bus.Seg}, {1'b0, 7'b0100000});

        // Asynchronous reset while a digit is being driven.
        #2 reset = 1'b1;
        #1;
        checkOutput("async_rst_an", {4'b0, bus.an}, 8'h0F);
        checkOutput("async_rst_seg", {1'b0, bus.Seg}, 8'h7F);
        checkOutput("async_rst_dp", {7'b0, bus.dp}, 8'h01);
        checkOutput("async_rst_fd", {7'b0, bus.frame_done}, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        curT = -1;
        fdCount = 0;
        for (int t = 0; t < 2 * FRAME; t++) begin
            advanceTo(t);
            if (bus.frame_done) fdCount++;
        end
        checkOutput("fd_count_2frames", 8'(fdCount), 8'd2);

        @(posedge clk);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
